// File: rtl/rv32i_types.sv
// Load/store micro-op types shared between decode and the memory path,
// plus the byte-lane helpers both sides need.
package rv32i_types;

   typedef enum logic [1:0] {
      MEM_LD = 2'd0,
      MEM_ST = 2'd1,
      MEM_NM = 2'd2
   } mem_fn_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } mem_size_t;

   typedef enum logic {
      EXT_S = 1'b0,
      EXT_Z = 1'b1
   } load_ext_t;

   function automatic logic [3:0] byte_enables(mem_size_t sz, logic [1:0] off);
      case (sz)
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(mem_size_t sz, logic [1:0] off);
      case (sz)
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Lines a returned cache word up to its byte offset and sign/zero extends
// it to the load size. Purely combinational so forwarding logic can reuse it.
module load_align
   import rv32i_types::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  mem_size_t   size,
   input  load_ext_t   ext,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (size)
         SZ_B:    result = (ext == EXT_S) ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h0, shifted[7:0]};
         SZ_H:    result = (ext == EXT_S) ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'h0, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/mem_resp_unit.sv
// Single-outstanding data-memory access unit: issues the word-aligned cache
// request, waits for the response and hands the aligned result to writeback.
module mem_resp_unit
   import rv32i_types::*;
#(
   parameter int TAG_W = 6
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  mem_fn_t          req_fn,
   input  mem_size_t        req_sz,
   input  load_ext_t        req_ext,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             dmem_read,
   output logic             dmem_write,
   output logic [31:0]      dmem_addr,
   output logic [3:0]       dmem_mbe,
   output logic [31:0]      dmem_wdata,
   input  logic [31:0]      dmem_rdata,
   input  logic             dmem_resp,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [TAG_W-1:0] wb_tag,
   output logic [31:0]      wb_data,
   output logic             wb_misalign
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state;
   logic [1:0]       off_q;
   mem_size_t        sz_q;
   load_ext_t        ext_q;
   logic [TAG_W-1:0] tag_q;
   logic [31:0]      load_result;

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .offset (off_q),
      .size   (sz_q),
      .ext    (ext_q),
      .result (load_result)
   );

   assign req_ready = (state == S_IDLE);

   // The cache strobe and its address/lanes are only cleared on a response,
   // so a flushed access drains instead of withdrawing mid-transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         off_q       <= 2'b00;
         sz_q        <= SZ_B;
         ext_q       <= EXT_S;
         tag_q       <= '0;
         dmem_read   <= 1'b0;
         dmem_write  <= 1'b0;
         dmem_addr   <= 32'h0;
         dmem_mbe    <= 4'h0;
         dmem_wdata  <= 32'h0;
         wb_valid    <= 1'b0;
         wb_tag      <= '0;
         wb_data     <= 32'h0;
         wb_misalign <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && !flush) begin
                  off_q <= req_addr[1:0];
                  sz_q  <= req_sz;
                  ext_q <= req_ext;
                  tag_q <= req_tag;
                  if (req_fn == MEM_NM || is_misaligned(req_sz, req_addr[1:0])) begin
                     state       <= S_DONE;
                     wb_valid    <= 1'b1;
                     wb_tag      <= req_tag;
                     wb_data     <= 32'h0;
                     wb_misalign <= (req_fn != MEM_NM);
                  end else begin
                     state      <= S_ACCESS;
                     dmem_read  <= (req_fn == MEM_LD);
                     dmem_write <= (req_fn == MEM_ST);
                     dmem_addr  <= {req_addr[31:2], 2'b00};
                     dmem_mbe   <= byte_enables(req_sz, req_addr[1:0]);
                     dmem_wdata <= (req_fn == MEM_ST) ? (req_wdata << {req_addr[1:0], 3'b000})
                                                      : 32'h0;
                  end
               end
            end
            S_ACCESS: begin
               if (dmem_resp) begin
                  dmem_read  <= 1'b0;
                  dmem_write <= 1'b0;
                  dmem_addr  <= 32'h0;
                  dmem_mbe   <= 4'h0;
                  dmem_wdata <= 32'h0;
                  if (flush) begin
                     state <= S_IDLE;
                  end else begin
                     state       <= S_DONE;
                     wb_valid    <= 1'b1;
                     wb_tag      <= tag_q;
                     wb_data     <= dmem_read ? load_result : 32'h0;
                     wb_misalign <= 1'b0;
                  end
               end else if (flush) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (dmem_resp) begin
                  state      <= S_IDLE;
                  dmem_read  <= 1'b0;
                  dmem_write <= 1'b0;
                  dmem_addr  <= 32'h0;
                  dmem_mbe   <= 4'h0;
                  dmem_wdata <= 32'h0;
               end
            end
            S_DONE: begin
               if (flush || wb_ready) begin
                  state       <= S_IDLE;
                  wb_valid    <= 1'b0;
                  wb_tag      <= '0;
                  wb_data     <= 32'h0;
                  wb_misalign <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_resp_unit.sv
// Directed and randomized load/store traffic against mem_resp_unit, checked
// with a byte-arithmetic reference model of the access rules.
module tb_mem_resp_unit;
   import rv32i_types::*;

   localparam int TAG_W = 6;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   mem_fn_t          req_fn;
   mem_size_t        req_sz;
   load_ext_t        req_ext;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [TAG_W-1:0] req_tag;
   logic             flush;
   logic             dmem_read;
   logic             dmem_write;
   logic [31:0]      dmem_addr;
   logic [3:0]       dmem_mbe;
   logic [31:0]      dmem_wdata;
   logic [31:0]      dmem_rdata;
   logic             dmem_resp;
   logic             wb_valid;
   logic             wb_ready;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_data;
   logic             wb_misalign;

   int n_checks;
   int n_fail;

   mem_resp_unit #(.TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_fn      (req_fn),
      .req_sz      (req_sz),
      .req_ext     (req_ext),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_tag     (req_tag),
      .flush       (flush),
      .dmem_read   (dmem_read),
      .dmem_write  (dmem_write),
      .dmem_addr   (dmem_addr),
      .dmem_mbe    (dmem_mbe),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_resp   (dmem_resp),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_tag      (wb_tag),
      .wb_data     (wb_data),
      .wb_misalign (wb_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: pick the addressed bytes out of the word and extend
   // them with signed integer arithmetic.
   function automatic logic [31:0] ref_load(logic [31:0] rdata, int off, mem_size_t sz, load_ext_t ext);
      longint v;
      v = longint'(rdata) / (longint'(1) << (8 * off));
      if (sz == SZ_B) begin
         v = v % 256;
         if (ext == EXT_S && v >= 128) v = v - 256;
      end else if (sz == SZ_H) begin
         v = v % 65536;
         if (ext == EXT_S && v >= 32768) v = v - 65536;
      end
      return v[31:0];
   endfunction

   function automatic logic [3:0] ref_mbe(mem_size_t sz, int off);
      if (sz == SZ_B) return 4'(1 << off);
      if (sz == SZ_H) return (off >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic ref_misaligned(mem_size_t sz, int off);
      return (sz == SZ_H && off % 2 != 0) || (sz == SZ_W && off != 0);
   endfunction

   task automatic applyStimulus(input mem_fn_t fn, input mem_size_t sz, input load_ext_t ext,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [TAG_W-1:0] tag, input logic [31:0] rdata,
                                input int nwait);
      int          off;
      logic        mis;
      logic [31:0] exp_data;
      int          hold;
      off = int'(addr % 4);
      mis = (fn != MEM_NM) && ref_misaligned(sz, off);
      checkOutput("ready_before_accept", {31'h0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_fn    = fn;
      req_sz    = sz;
      req_ext   = ext;
      req_addr  = addr;
      req_wdata = wdata;
      req_tag   = tag;
      step();
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      checkOutput("ready_busy", {31'h0, req_ready}, 32'd0);
      if (fn == MEM_NM || mis) begin
         exp_data = 32'h0;
         checkOutput("fast_wb_valid", {31'h0, wb_valid}, 32'd1);
         checkOutput("fast_misalign", {31'h0, wb_misalign}, {31'h0, mis});
         checkOutput("fast_no_strobe", {30'h0, dmem_read, dmem_write}, 32'd0);
      end else begin
         exp_data = (fn == MEM_LD) ? ref_load(rdata, off, sz, ext) : 32'h0;
         checkOutput("strobe_read", {31'h0, dmem_read}, {31'h0, fn == MEM_LD});
         checkOutput("strobe_write", {31'h0, dmem_write}, {31'h0, fn == MEM_ST});
         checkOutput("dmem_addr", dmem_addr, addr - 32'(off));
         checkOutput("dmem_mbe", {28'h0, dmem_mbe}, {28'h0, ref_mbe(sz, off)});
         if (fn == MEM_ST) checkOutput("dmem_wdata", dmem_wdata, wdata * (32'd1 << (8 * off)));
         for (int i = 0; i < nwait; i++) begin
            step();
            checkOutput("strobe_held", {31'h0, dmem_read | dmem_write}, 32'd1);
            checkOutput("no_early_valid", {31'h0, wb_valid}, 32'd0);
         end
         dmem_resp  = 1'b1;
         dmem_rdata = rdata;
         step();
         dmem_resp  = 1'b0;
         dmem_rdata = $urandom;
         checkOutput("resp_wb_valid", {31'h0, wb_valid}, 32'd1);
         checkOutput("strobe_dropped", {30'h0, dmem_read, dmem_write}, 32'd0);
         checkOutput("mbe_cleared", {28'h0, dmem_mbe}, 32'd0);
         checkOutput("addr_cleared", dmem_addr, 32'd0);
         checkOutput("resp_misalign", {31'h0, wb_misalign}, 32'd0);
      end
      checkOutput("wb_data", wb_data, exp_data);
      checkOutput("wb_tag", {26'h0, wb_tag}, {26'h0, tag});
      hold = $urandom_range(0, 2);
      for (int i = 0; i < hold; i++) begin
         step();
         checkOutput("hold_valid", {31'h0, wb_valid}, 32'd1);
         checkOutput("hold_data", wb_data, exp_data);
      end
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
      checkOutput("wb_handshake_valid", {31'h0, wb_valid}, 32'd0);
      checkOutput("wb_handshake_ready", {31'h0, req_ready}, 32'd1);
   endtask

   initial begin
      mem_fn_t     rfn;
      mem_size_t   rsz;
      logic [31:0] raddr;
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b1;
      req_valid  = 1'b0;
      req_fn     = MEM_LD;
      req_sz     = SZ_B;
      req_ext    = EXT_S;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_tag    = '0;
      flush      = 1'b0;
      dmem_rdata = 32'h0;
      dmem_resp  = 1'b0;
      wb_ready   = 1'b0;
      #1 rst_n = 1'b0;
      step();
      step();
      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'd1);
      checkOutput("rst_strobes", {30'h0, dmem_read, dmem_write}, 32'd0);
      checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
      checkOutput("rst_wb", {25'h0, wb_valid, wb_misalign, wb_tag}, 32'd0);
      checkOutput("rst_wb_data", wb_data, 32'd0);
      rst_n = 1'b1;
      step();

      $display("[TB] directed accesses");
      applyStimulus(MEM_LD, SZ_B, EXT_S, 32'h0000_0103, 32'h0, 6'h11, 32'h80AA_BBCC, 2);
      applyStimulus(MEM_LD, SZ_H, EXT_Z, 32'h0000_0202, 32'h0, 6'h12, 32'h8001_1234, 1);
      applyStimulus(MEM_LD, SZ_H, EXT_S, 32'h0000_0200, 32'h0, 6'h13, 32'h8001_1234, 1);
      applyStimulus(MEM_ST, SZ_B, EXT_S, 32'h0000_0301, 32'h0000_00EE, 6'h14, 32'h0, 1);
      applyStimulus(MEM_LD, SZ_W, EXT_S, 32'h0000_0402, 32'h0, 6'h15, 32'h0, 1);
      applyStimulus(MEM_NM, SZ_W, EXT_S, 32'h0000_0500, 32'h0, 6'h16, 32'h0, 1);
      applyStimulus(MEM_ST, SZ_H, EXT_S, 32'h0000_0602, 32'h0000_BEEF, 6'h17, 32'h0, 3);

      $display("[TB] randomized accesses");
      for (int n = 0; n < 40; n++) begin
         rfn   = mem_fn_t'($urandom_range(0, 2));
         rsz   = mem_size_t'($urandom_range(0, 2));
         raddr = $urandom;
         applyStimulus(rfn, rsz, load_ext_t'($urandom_range(0, 1)), raddr, $urandom,
                       TAG_W'($urandom), $urandom, $urandom_range(1, 4));
      end

      $display("[TB] flush in access, drain until response");
      req_valid = 1'b1; req_fn = MEM_LD; req_sz = SZ_W; req_addr = 32'h0000_0700; req_tag = 6'h21;
      step();
      req_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checkOutput("drain_read_held", {31'h0, dmem_read}, 32'd1);
         checkOutput("drain_no_valid", {31'h0, wb_valid}, 32'd0);
         checkOutput("drain_not_ready", {31'h0, req_ready}, 32'd0);
         step();
      end
      checkOutput("drain_read_last", {31'h0, dmem_read}, 32'd1);
      dmem_resp = 1'b1;
      step();
      dmem_resp = 1'b0;
      checkOutput("drain_read_off", {31'h0, dmem_read}, 32'd0);
      checkOutput("drain_ready", {31'h0, req_ready}, 32'd1);
      checkOutput("drain_no_valid_end", {31'h0, wb_valid}, 32'd0);
      step();
      checkOutput("drain_no_late_valid", {31'h0, wb_valid}, 32'd0);

      $display("[TB] flush and response together");
      req_valid = 1'b1; req_fn = MEM_ST; req_sz = SZ_B; req_addr = 32'h0000_0801;
      step();
      req_valid = 1'b0;
      flush = 1'b1; dmem_resp = 1'b1;
      step();
      flush = 1'b0; dmem_resp = 1'b0;
      checkOutput("fr_ready", {31'h0, req_ready}, 32'd1);
      checkOutput("fr_no_valid", {31'h0, wb_valid}, 32'd0);
      checkOutput("fr_strobe_off", {30'h0, dmem_read, dmem_write}, 32'd0);

      $display("[TB] request with flush in idle is ignored");
      req_valid = 1'b1; flush = 1'b1; req_fn = MEM_LD; req_addr = 32'h0000_0900;
      step();
      req_valid = 1'b0; flush = 1'b0;
      checkOutput("idle_flush_ready", {31'h0, req_ready}, 32'd1);
      checkOutput("idle_flush_strobe", {31'h0, dmem_read}, 32'd0);
      checkOutput("idle_flush_valid", {31'h0, wb_valid}, 32'd0);

      $display("[TB] done held, then flush beats wb_ready");
      req_valid = 1'b1; req_fn = MEM_LD; req_sz = SZ_W; req_addr = 32'h0000_0A03; req_tag = 6'h2A;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("done_hold_valid", {31'h0, wb_valid}, 32'd1);
         checkOutput("done_hold_tag", {26'h0, wb_tag}, 32'h2A);
         checkOutput("done_hold_mis", {31'h0, wb_misalign}, 32'd1);
         step();
      end
      wb_ready = 1'b1; flush = 1'b1;
      step();
      wb_ready = 1'b0; flush = 1'b0;
      checkOutput("done_flush_valid", {31'h0, wb_valid}, 32'd0);
      checkOutput("done_flush_ready", {31'h0, req_ready}, 32'd1);
      step();
      checkOutput("done_no_second_valid", {31'h0, wb_valid}, 32'd0);

      $display("[TB] asynchronous reset mid-access");
      req_valid = 1'b1; req_fn = MEM_ST; req_sz = SZ_W; req_addr = 32'h0000_0B00; req_wdata = 32'hCAFE_F00D;
      step();
      req_valid = 1'b0;
      checkOutput("pre_reset_write", {31'h0, dmem_write}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_strobes", {30'h0, dmem_read, dmem_write}, 32'd0);
      checkOutput("arst_addr", dmem_addr, 32'd0);
      checkOutput("arst_mbe", {28'h0, dmem_mbe}, 32'd0);
      checkOutput("arst_wdata", dmem_wdata, 32'd0);
      checkOutput("arst_ready", {31'h0, req_ready}, 32'd1);
      checkOutput("arst_wb", {25'h0, wb_valid, wb_misalign, wb_tag}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_resp_unit.md
# mem_resp_unit

Data-memory access unit: the response side of the load/store path. It accepts one decoded load/store micro-op (function, size, extension, byte address, store data, tag) from the issue side and drives the word-aligned data-cache request with byte enables. It holds the request until the cache responds, then aligns and extends the returned load word and presents the result to writeback under a valid/ready handshake. It sits between the memory issue slot and the writeback arbiter and keeps at most one access outstanding.

## Interface
- `TAG_W`, 6: width of the micro-op tag carried to writeback.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: issue side presents a micro-op.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_fn` in `mem_fn_t`: ld / st / nm.
- `req_sz` in `mem_size_t`: b / h / w.
- `req_ext` in `load_ext_t`: s / z; ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_tag` in TAG_W: micro-op tag.
- `flush` in 1: kill the current micro-op.
- `dmem_read` out 1: cache read strobe.
- `dmem_write` out 1: cache write strobe.
- `dmem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_mbe` out 4: byte enables.
- `dmem_wdata` out 32: lane-shifted store data.
- `dmem_rdata` in 32: returned word.
- `dmem_resp` in 1: one-cycle response pulse.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: writeback accepts.
- `wb_tag` out TAG_W: tag of the result.
- `wb_data` out 32: load result; 0 for stores.
- `wb_misalign` out 1: access was misaligned; no memory access was made.

## Operation
- FSM states are IDLE, ACCESS, DRAIN and DONE.
- **IDLE**
  - On `req_valid && req_ready`, capture all `req_*` fields.
  - `fn=nm` goes directly to DONE with `wb_data=0`.
  - Misaligned accesses go to DONE with `wb_misalign=1`. Misaligned means h with `addr[0]=1`, or w with `addr[1:0]!=0`.
  - Otherwise go to ACCESS.
- **ACCESS**
  - Assert `dmem_read` (ld) or `dmem_write` (st) continuously; `dmem_addr`, `dmem_mbe` and `dmem_wdata` stay stable.
  - On `dmem_resp`, capture the formatted result and go to DONE.
  - If `flush` is sampled high without `dmem_resp`, go to DRAIN.
  - If `flush` and `dmem_resp` are sampled high in the same cycle, go to IDLE.
- **DRAIN**
  - Keep the strobe asserted until `dmem_resp`, then go to IDLE with no writeback. The cache request is never withdrawn mid-transaction.
- **DONE**
  - `wb_valid=1`; all `wb_*` outputs are held stable.
  - `wb_ready` returns to IDLE.
  - `flush` returns to IDLE without writeback; `flush` wins over `wb_ready`.
- `flush` in IDLE has no effect, and a request presented in the same cycle as `flush` is not accepted.
- **Byte enables**
  - b gives `0001 << addr[1:0]`.
  - h gives `0011` when `addr[1]=0`, `1100` when `addr[1]=1`.
  - w gives `1111`.
- **Store data:** `dmem_wdata = req_wdata << (8*addr[1:0])`.
- **Load data:** shift `dmem_rdata >> (8*addr[1:0])`, then
  - b: bit 7 is sign-extended (s) or zero-extended (z);
  - h: bit 15 is sign-extended (s) or zero-extended (z);
  - w: passed through.

## Timing
- **Reset values:** state=IDLE, `req_ready=1`, `dmem_read=0`, `dmem_write=0`, `dmem_addr=0`, `dmem_mbe=0`, `dmem_wdata=0`, `wb_valid=0`, `wb_tag=0`, `wb_data=0`, `wb_misalign=0`.
- Reset mid-access abandons the transaction immediately; the cache is reset by the same `rst_n`.
- Strobes rise the cycle after acceptance and fall the cycle after `dmem_resp` is sampled.
- Minimum latency, acceptance to `wb_valid`:
  - 1 cycle for nm or misaligned;
  - N+1 cycles when `dmem_resp` arrives N cycles after the strobe rises (N≥1).
- Back-to-back throughput: one micro-op per (latency+1) cycles, because `req_ready` rises the cycle after the `wb` handshake.
- `dmem_mbe`, `dmem_addr` and `dmem_wdata` are registered and are 0 outside ACCESS and DRAIN.

## Structure
- `mem_fn_t` (ld/st/nm), `mem_size_t` (b/h/w) and `load_ext_t` (s/z) live in `rv32i_types`, shared with the decode stage. The FSM state enum stays local.
- One combinational sub-module, `load_align`, takes (`rdata`, `offset[1:0]`, `size`, `ext`) and outputs a 32-bit word. It is instantiated once and reused by future LSQ forwarding logic.

## Test plan
- lb at addr 0x103 with `dmem_rdata=0x80AA_BBCC`, resp after 2 cycles -> `dmem_mbe=1000`, `dmem_addr=0x100`, `wb_data=0xFFFF_FF80`, `wb_valid` 3 cycles after acceptance.
- lhu at 0x202 with rdata 0x8001_1234 -> `mbe=1100`, `wb_data=0x0000_8001`. lh at 0x200 with the same rdata -> `wb_data=0x0000_1234`.
- sb at 0x301 with `req_wdata=0x0000_00EE` -> `dmem_write=1`, `mbe=0010`, `dmem_wdata=0x0000_EE00`, `wb_data=0`.
- lw at 0x402 -> no strobe ever asserted; `wb_misalign=1` one cycle after acceptance.
- flush in ACCESS at cycle 1, resp at cycle 4 -> `dmem_read` held through cycle 4, `wb_valid` never rises, `req_ready=1` at cycle 5.
- DONE with `wb_ready=0` for 5 cycles -> outputs stable. Then `wb_ready=1` and `flush=1` together -> IDLE with no second valid; `rst_n` low mid-ACCESS -> every output at its reset value asynchronously.
